clk_div_ratio_ctrl: RTL and testbench

Runtime-programmable, glitch-free clock-divider controller. Generates a 50%-duty divided clock from `clk` using an even ratio held in an internal active-ratio register. Ratio changes are accepted over a valid/ready handshake and applied only at a period boundary. Enable/disable completes the current high phase, so `clk_out` never emits a runt pulse. The block sits between the configuration registers and any logic clocked or enabled by the divided clock.

---
 rtl/clk_div_ratio_ctrl.sv | 122 ++++++++++++
 tb/tb_clk_div_ratio_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/clk_div_ratio_ctrl.sv
// Glitch-free programmable clock divider: 50%-duty output at an even ratio,
// ratio updates over valid/ready applied only at a falling period boundary.
module clk_div_ratio_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic [DIV_W-1:0] cur_div,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [DIV_W-2:0] CNT_ONE = 1;

  state_t           state_q;
  logic [DIV_W-2:0] count_q;
  logic [DIV_W-1:0] cur_div_q;
  logic [DIV_W-1:0] pend_div_q;
  logic             pend_valid_q;
  logic             clk_out_q;
  logic             rise_q;
  logic             cfg_err_q;

  logic [DIV_W-2:0] half;
  logic             accept;
  logic             legal;
  logic             toggle;

  // Even, at least 2, and not the all-ones code.
  function automatic logic is_legal(input logic [DIV_W-1:0] n);
    return (n[0] == 1'b0) && (n[DIV_W-1:1] != '0) && (n != '1);
  endfunction

  assign half   = cur_div_q[DIV_W-1:1];
  assign accept = cfg_valid && !pend_valid_q;
  assign legal  = is_legal(cfg_div);
  assign toggle = (count_q == (half - CNT_ONE));

  always_ff @(posedge clk) begin
    if (accept && legal) begin
      pend_div_q <= cfg_div;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      cur_div_q    <= DIV_W'(DEFAULT_DIV);
      pend_valid_q <= 1'b0;
      clk_out_q    <= 1'b0;
      rise_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      cfg_err_q <= accept && !legal;
      rise_q    <= 1'b0;

      case (state_q)
        IDLE: begin
          count_q   <= '0;
          clk_out_q <= 1'b0;
          // A ratio left pending by a low-phase stop is applied here.
          if (pend_valid_q) begin
            cur_div_q    <= pend_div_q;
            pend_valid_q <= 1'b0;
          end
          if (accept && legal) begin
            cur_div_q <= cfg_div;
          end
          if (en) begin
            state_q <= RUN;
          end
        end

        RUN, DRAIN: begin
          if (state_q == RUN && !en && !clk_out_q) begin
            state_q <= IDLE;
            count_q <= '0;
          end else if (toggle) begin
            count_q   <= '0;
            clk_out_q <= !clk_out_q;
            rise_q    <= !clk_out_q;
            if (clk_out_q) begin
              if (pend_valid_q) begin
                cur_div_q    <= pend_div_q;
                pend_valid_q <= 1'b0;
              end
              state_q <= en ? RUN : IDLE;
            end else begin
              state_q <= RUN;
            end
          end else begin
            count_q <= count_q + CNT_ONE;
            state_q <= en ? RUN : DRAIN;
          end
          if (accept && legal) begin
            pend_valid_q <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_ready  = !pend_valid_q;
  assign cfg_err    = cfg_err_q;
  assign clk_out    = clk_out_q;
  assign rise_pulse = rise_q;
  assign cur_div    = cur_div_q;
  assign busy       = (state_q != IDLE) || pend_valid_q;

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Directed bench for clk_div_ratio_ctrl: per-cycle expected outputs are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_clk_div_ratio_ctrl;

  localparam int DIV_W = 8;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             en        = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [DIV_W-1:0] cfg_div   = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             rise_pulse;
  logic [DIV_W-1:0] cur_div;
  logic             busy;

  clk_div_ratio_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .rise_pulse (rise_pulse),
    .cur_div    (cur_div),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] v;
    int          idx;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mx;
  logic [12:0] got;
  int          checks   = 0;
  int          failures = 0;
  int          step_n   = 0;

  // One clock: drive inputs, take the edge, queue the expected post-edge outputs.
  task automatic st(input logic r, input logic e, input logic v,
                    input logic [DIV_W-1:0] d,
                    input logic co, input logic rp, input logic er,
                    input logic rd, input logic bz,
                    input logic [DIV_W-1:0] cd);
    exp_t x;
    rst       = r;
    en        = e;
    cfg_valid = v;
    cfg_div   = d;
    @(posedge clk);
    #1;
    step_n++;
    x.v   = {co, rp, er, rd, bz, cd};
    x.idx = step_n;
    exp_q.push_back(x);
  endtask

  // n enabled cycles with constant clk_out; rise_pulse only on the first one.
  task automatic hold(input int n, input logic co, input logic rf,
                      input logic rd, input logic [DIV_W-1:0] cd);
    for (int i = 0; i < n; i++) begin
      st(1'b0, 1'b1, 1'b0, '0, co, (i == 0) ? rf : 1'b0, 1'b0, rd, 1'b1, cd);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mx  = exp_q.pop_front();
      got = {clk_out, rise_pulse, cfg_err, cfg_ready, busy, cur_div};
      checks++;
      if (got !== mx.v) begin
        failures++;
        $display("FAIL step%0d got co=%b rp=%b er=%b rd=%b bz=%b cd=%0d required co=%b rp=%b er=%b rd=%b bz=%b cd=%0d",
                 mx.idx, got[12], got[11], got[10], got[9], got[8], got[7:0],
                 mx.v[12], mx.v[11], mx.v[10], mx.v[9], mx.v[8], mx.v[7:0]);
      end
    end
  end

  initial begin
    // Reset and start-up at the default ratio of 4
    st(1, 0, 0, 0,   0, 0, 0, 1, 0, 4);
    st(1, 0, 0, 0,   0, 0, 0, 1, 0, 4);
    st(0, 0, 0, 0,   0, 0, 0, 1, 0, 4);
    st(0, 1, 0, 0,   0, 0, 0, 1, 1, 4);
    hold(1, 0, 0, 1, 4);
    hold(2, 1, 1, 1, 4);
    hold(2, 0, 0, 1, 4);
    hold(2, 1, 1, 1, 4);
    hold(2, 0, 0, 1, 4);
    hold(1, 1, 1, 1, 4);

    // Illegal ratios 7, 0, 255 back to back
    st(0, 1, 1, 7,   1, 0, 1, 1, 1, 4);
    st(0, 1, 1, 0,   0, 0, 1, 1, 1, 4);
    st(0, 1, 1, 255, 0, 0, 1, 1, 1, 4);
    hold(2, 1, 1, 1, 4);
    hold(2, 0, 0, 1, 4);
    hold(1, 1, 1, 1, 4);

    // Offer 10 mid-high-phase, applied at the next falling boundary
    st(0, 1, 1, 10,  1, 0, 0, 0, 1, 4);
    st(0, 1, 0, 0,   0, 0, 0, 1, 1, 10);
    hold(4, 0, 0, 1, 10);
    hold(5, 1, 1, 1, 10);
    hold(5, 0, 0, 1, 10);

    // Offer 6 on a rising toggle; stays pending for the whole high phase
    st(0, 1, 1, 6,   1, 1, 0, 0, 1, 10);
    hold(4, 1, 0, 0, 10);
    st(0, 1, 0, 0,   0, 0, 0, 1, 1, 6);
    hold(2, 0, 0, 1, 6);
    hold(1, 1, 1, 1, 6);

    // en drops in the first high cycle at div 6: drain then IDLE
    st(0, 0, 0, 0,   1, 0, 0, 1, 1, 6);
    st(0, 0, 0, 0,   1, 0, 0, 1, 1, 6);
    st(0, 0, 0, 0,   0, 0, 0, 1, 0, 6);
    st(0, 0, 0, 0,   0, 0, 0, 1, 0, 6);

    // en drops during a low phase: IDLE on the next edge
    st(0, 1, 0, 0,   0, 0, 0, 1, 1, 6);
    st(0, 1, 0, 0,   0, 0, 0, 1, 1, 6);
    st(0, 0, 0, 0,   0, 0, 0, 1, 0, 6);
    st(0, 0, 0, 0,   0, 0, 0, 1, 0, 6);

    // One-cycle en glitch in a high phase leaves the waveform intact
    st(0, 1, 0, 0,   0, 0, 0, 1, 1, 6);
    hold(2, 0, 0, 1, 6);
    hold(1, 1, 1, 1, 6);
    st(0, 0, 0, 0,   1, 0, 0, 1, 1, 6);
    st(0, 1, 0, 0,   1, 0, 0, 1, 1, 6);
    hold(3, 0, 0, 1, 6);
    hold(3, 1, 1, 1, 6);

    // Offer 10 on a falling boundary, then reset discards it
    st(0, 1, 1, 10,  0, 0, 0, 0, 1, 6);
    st(1, 1, 0, 0,   0, 0, 0, 1, 0, 4);
    st(0, 0, 0, 0,   0, 0, 0, 1, 0, 4);
    st(0, 1, 0, 0,   0, 0, 0, 1, 1, 4);
    hold(1, 0, 0, 1, 4);
    hold(2, 1, 1, 1, 4);
    hold(2, 0, 0, 1, 4);

    // Stop, then cfg and en together in IDLE at the minimum ratio 2
    st(0, 0, 0, 0,   0, 0, 0, 1, 0, 4);
    st(0, 1, 1, 2,   0, 0, 0, 1, 1, 2);
    hold(1, 1, 1, 1, 2);
    hold(1, 0, 0, 1, 2);
    hold(1, 1, 1, 1, 2);
    hold(1, 0, 0, 1, 2);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain left=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
